button_array: RTL and testbench
===============================

// Module: button_array
// PURPOSE
// Multi-channel successor to the single-button SoC interface. It synchronises and debounces
// NBTN push-buttons and keeps a debounced level per channel. It captures sticky press and
// release events that the CPU reads over the address bus, with clear-on-access.
// It also drives a level interrupt while any press event is pending.
// Sits on the SoC read bus beside the other memory-mapped peripherals.
// PARAMETERS
// CLKRATE   25000000  system clock frequency, Hz
// DBMSEC    150       debounce window, ms; DBMAX = CLKRATE/1000*DBMSEC cycles (DBMAX >= 2)
// NBTN      4         number of button channels, 1..32
// BASEADDR  411700    press-flag register address; level = BASEADDR+4, release = BASEADDR+8
// ACTIVELOW 1         1: key pin low = pressed; 0: key pin high = pressed
// PORTS
// clk      in   1     system clock, all logic on posedge
// rst      in   1     asynchronous, active-high reset
// key      in   NBTN  raw asynchronous button pins
// busaddr  in   32    CPU bus address
// busdata  out  32    read data, combinational from busaddr, zero-extended above NBTN
// irq      out  1     high while any press flag is set
// BEHAVIOUR
// - Reset (async, rst=1): sync flops = released pin level; debounced level, press/release flags
//   and debounce counters = 0; busdata = 0 unless an address is decoded; irq = 0.
// - Sync: per channel, 2-flop synchroniser. Normalise pressed=1 using ACTIVELOW. s = sync output.
// - Debounce counter: per channel, width $clog2(DBMAX+1), saturation-free.
//   - s == level: counter <= 0.
//   - s != level and counter < DBMAX-1: counter <= counter+1.
//   - s != level and counter == DBMAX-1: level <= s, counter <= 0, and one event flag is set:
//     press if the new level is 1, release if it is 0.
// - A glitch shorter than DBMAX cycles never changes level. Any return of s to level restarts
//   the count from 0.
// - Latency: a clean pin change updates level and the flag 2+DBMAX clk edges later.
// - Channels are fully independent. Simultaneous events on several channels all set their bits
//   in the same cycle.
// - Read map (combinational):
//   - BASEADDR   -> {0, press[NBTN-1:0]}
//   - BASEADDR+4 -> {0, level}
//   - BASEADDR+8 -> {0, release}
//   - any other address -> 32'h0
// - Clear-on-access: each cycle busaddr == BASEADDR, all press flags clear at the next edge.
//   Same rule for BASEADDR+8 and the release flags. Level is never cleared by a read.
// - busdata shows the flag values before the clear. A held address reads the value once,
//   then 0.
// - Set/clear collision: if an event sets a flag in the same cycle its register is accessed,
//   set wins. The bit reads 1 afterwards, so no event is lost.
// - A second press before the flag is read leaves it 1 (no count, no overflow indication).
// - irq = |press, registered with the flags; it falls the cycle after press is cleared.
// - rst asserted mid-count: counter, level and flags return to 0 at once. After release,
//   a still-held button needs a full 2+DBMAX cycles before a new press event.
// TESTING (bench: CLKRATE=10000, DBMSEC=1 -> DBMAX=10, NBTN=4, ACTIVELOW=1)
// 1. key[0] low at cycle 0 and held, no reads -> level[0]=1 and press=4'b0001 at edge 12,
//    irq=1; the BASEADDR+4 read returns 32'h1.
// 2. key[1] low for 6 cycles, then high; repeat 5 times -> level, press and release stay 0;
//    irq stays 0.
// 3. Press then release key[2] cleanly, then read BASEADDR+8 one cycle ->
//    busdata=32'h4 on that cycle, the next read returns 0, and press bit 2 is still 1.
// 4. Read BASEADDR on the exact cycle key[3]'s press completes -> the read returns the old
//    value, bit 3 stays set, and the next read returns 32'h8.
// 5. Press keys 0 and 3 together -> press=4'b1001 in the same cycle. An access at address
//    411704+8+4 returns 0.
// 6. Assert rst at count 7 of a held press -> all 0 immediately. After release of rst,
//    the press appears 12 cycles later.

Source files
------------

// File: rtl/button_array_if.sv
// button_array_if: CPU read bus, button pins and interrupt for the button array.
interface button_array_if #(parameter int NBTN = 4);
    logic [NBTN-1:0] key;
    logic [31:0]     busaddr;
    logic [31:0]     busdata;
    logic            irq;
    modport master(output key, busaddr, input busdata, irq);
    modport slave(input key, busaddr, output busdata, irq);
endinterface

// File: rtl/button_array.sv
// button_array: synchronised, debounced push-buttons with sticky press/release flags,
// clear-on-read bus registers and a press interrupt.
module button_array #(
    parameter int CLKRATE   = 25000000,
    parameter int DBMSEC    = 150,
    parameter int NBTN      = 4,
    parameter int BASEADDR  = 411700,
    parameter int ACTIVELOW = 1
) (
    input logic            clk,
    input logic            rst,
    button_array_if.slave  bus
);
    localparam int DBMAX = CLKRATE / 1000 * DBMSEC;
    localparam int CW    = $clog2(DBMAX + 1);
    localparam logic [NBTN-1:0] IDLE = {NBTN{1'(ACTIVELOW)}};

    logic [NBTN-1:0] sync1_q, sync2_q, level_q, level_d, press_q, press_d, rel_q, rel_d, s;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];
    logic            rd_press, rd_level, rd_rel;

    assign s        = sync2_q ^ IDLE;
    assign rd_press = bus.busaddr == 32'(BASEADDR);
    assign rd_level = bus.busaddr == 32'(BASEADDR + 4);
    assign rd_rel   = bus.busaddr == 32'(BASEADDR + 8);

    // A completing event is OR-ed in after the read clear, so a colliding set survives.
    always_comb begin
        level_d = level_q;
        press_d = press_q & ~{NBTN{rd_press}};
        rel_d   = rel_q & ~{NBTN{rd_rel}};
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CW'(DBMAX - 1)) begin
                    level_d[i] = s[i];
                    press_d[i] = press_d[i] | s[i];
                    rel_d[i]   = rel_d[i] | ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= bus.key;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        bus.busdata = rd_press ? 32'(press_q) :
                      rd_level ? 32'(level_q) :
                      rd_rel   ? 32'(rel_q)   : 32'h0;
        bus.irq     = |press_q;
    end
endmodule

// File: tb/tb_button_array.sv
// tb_button_array: directed stimulus checked against a window-based debounce model
// every cycle, plus hand-computed expectations for each scenario.
module tb_button_array;
    localparam int DBMAX = 10;
    localparam logic [31:0] A_PRS = 32'd411700;
    localparam logic [31:0] A_LVL = 32'd411704;
    localparam logic [31:0] A_REL = 32'd411708;
    localparam logic [31:0] A_BAD = 32'd411716;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    button_array_if #(.NBTN(4)) bus();

    button_array #(
        .CLKRATE(10000), .DBMSEC(1), .NBTN(4), .BASEADDR(411700), .ACTIVELOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Model: level flips once the synchronised value has disagreed with it on each
    // of the last DBMAX edges since reset.
    logic [3:0] pq[$];
    logic [3:0] sh[$];
    logic [3:0] lvl_m, prs_m, rel_m;

    task automatic model_clear();
        pq.delete();
        sh.delete();
        lvl_m = '0;
        prs_m = '0;
        rel_m = '0;
    endtask

    task automatic model_edge();
        logic [3:0] sv, set_p, set_r;
        bit diff;
        if (rst) begin
            model_clear();
            return;
        end
        pq.push_back(~bus.key);
        if (pq.size() > 3) void'(pq.pop_front());
        sv = (pq.size() == 3) ? pq[0] : 4'h0;
        sh.push_back(sv);
        if (sh.size() > DBMAX) void'(sh.pop_front());
        set_p = '0;
        set_r = '0;
        for (int c = 0; c < 4; c++) begin
            if (sh.size() == DBMAX) begin
                diff = 1'b1;
                foreach (sh[k]) if (sh[k][c] == lvl_m[c]) diff = 1'b0;
                if (diff) begin
                    if (lvl_m[c]) set_r[c] = 1'b1;
                    else set_p[c] = 1'b1;
                end
            end
        end
        lvl_m = lvl_m ^ (set_p | set_r);
        prs_m = ((bus.busaddr == A_PRS) ? 4'h0 : prs_m) | set_p;
        rel_m = ((bus.busaddr == A_REL) ? 4'h0 : rel_m) | set_r;
    endtask

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return a == A_PRS ? {28'h0, prs_m} :
               a == A_LVL ? {28'h0, lvl_m} :
               a == A_REL ? {28'h0, rel_m} : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            check("model_busdata", bus.busdata, model_data(bus.busaddr));
            check("model_irq", {31'h0, bus.irq}, {31'h0, |prs_m});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.key = 4'hF;
        bus.busaddr = A_LVL;
        model_clear();
        tick();
        tick();
        #1 check("rst_level", bus.busdata, 32'h0);
        check("rst_irq", {31'h0, bus.irq}, 32'h0);
        rst = 1'b0;
        // single press latency
        bus.key = 4'b1110;
        repeat (11) tick();
        #1 check("t1_level_e11", bus.busdata, 32'h0);
        tick();
        #1 check("t1_level_e12", bus.busdata, 32'h1);
        check("t1_irq", {31'h0, bus.irq}, 32'h1);
        bus.busaddr = A_PRS;
        #1 check("t1_press", bus.busdata, 32'h1);
        tick();
        #1 check("t1_press_cleared", bus.busdata, 32'h0);
        check("t1_irq_low", {31'h0, bus.irq}, 32'h0);
        bus.busaddr = A_LVL;
        bus.key = 4'hF;
        repeat (14) tick();
        bus.busaddr = A_REL;
        #1 check("t1_release", bus.busdata, 32'h1);
        tick();
        bus.busaddr = A_LVL;
        // short glitches on key[1]
        repeat (5) begin
            bus.key = 4'b1101;
            repeat (6) tick();
            bus.key = 4'hF;
            repeat (6) tick();
        end
        repeat (14) tick();
        #1 check("t2_level", bus.busdata, 32'h0);
        check("t2_irq", {31'h0, bus.irq}, 32'h0);
        bus.busaddr = A_PRS;
        #1 check("t2_press", bus.busdata, 32'h0);
        bus.busaddr = A_REL;
        #1 check("t2_release", bus.busdata, 32'h0);
        bus.busaddr = A_LVL;
        // press and release key[2], read release once
        bus.key = 4'b1011;
        repeat (14) tick();
        bus.key = 4'hF;
        repeat (14) tick();
        bus.busaddr = A_REL;
        #1 check("t3_release", bus.busdata, 32'h4);
        tick();
        #1 check("t3_release_again", bus.busdata, 32'h0);
        bus.busaddr = A_PRS;
        #1 check("t3_press_kept", bus.busdata, 32'h4);
        tick();
        bus.busaddr = A_LVL;
        // read press exactly as key[3] completes
        bus.key = 4'b0111;
        repeat (11) tick();
        bus.busaddr = A_PRS;
        #1 check("t4_old_value", bus.busdata, 32'h0);
        tick();
        #1 check("t4_set_wins", bus.busdata, 32'h8);
        tick();
        #1 check("t4_after_clear", bus.busdata, 32'h0);
        bus.busaddr = A_LVL;
        bus.key = 4'hF;
        repeat (14) tick();
        bus.busaddr = A_REL;
        tick();
        bus.busaddr = A_LVL;
        // simultaneous presses, unmapped address
        bus.key = 4'b0110;
        repeat (11) tick();
        #1 check("t5_level_e11", bus.busdata, 32'h0);
        tick();
        #1 check("t5_level_e12", bus.busdata, 32'h9);
        bus.busaddr = A_PRS;
        #1 check("t5_press", bus.busdata, 32'h9);
        bus.busaddr = A_BAD;
        #1 check("t5_unmapped", bus.busdata, 32'h0);
        tick();
        bus.busaddr = A_PRS;
        #1 check("t5_press_kept", bus.busdata, 32'h9);
        tick();
        bus.busaddr = A_LVL;
        bus.key = 4'hF;
        repeat (14) tick();
        bus.busaddr = A_REL;
        tick();
        bus.busaddr = A_LVL;
        // reset in the middle of a debounce count
        bus.key = 4'b1110;
        repeat (14) tick();
        bus.key = 4'b1100;
        repeat (9) tick();
        rst = 1'b1;
        model_clear();
        #1 check("t6_rst_level", bus.busdata, 32'h0);
        check("t6_rst_irq", {31'h0, bus.irq}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        repeat (11) tick();
        #1 check("t6_level_e11", bus.busdata, 32'h0);
        tick();
        #1 check("t6_level_e12", bus.busdata, 32'h3);
        bus.busaddr = A_PRS;
        #1 check("t6_press", bus.busdata, 32'h3);
        tick();
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
